// File: rtl/cordic_pipeline.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_pipeline
//  Description : Fully unrolled CORDIC engine with one register stage per
//                iteration. Rotation mode (arctan_en=0) rotates (x,0) by
//                degree_in. Vectoring mode (arctan_en=1) drives y to zero and
//                accumulates arctan(y/x) in z. Outputs carry the raw CORDIC
//                gain and are reduced from Q12.20 to Q7.8 with saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_pipeline #(
  parameter int INPUT_WIDTH               = 16,
  parameter int INPUT_FRAC_WIDTH          = 8,
  parameter int OUTPUT_WIDTH              = 16,
  parameter int OUTPUT_FRAC_WIDTH         = 8,
  parameter int ITERATION_NUMBER          = 6,
  parameter int ITERATION_WORD_WIDTH      = 32,
  parameter int ITERATION_WORD_FRAC_WIDTH = 20,
  parameter int FLIP_FLAG_WIDTH           = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [OUTPUT_WIDTH-1:0]    degree_in,
  input  logic [INPUT_WIDTH-1:0]     x_in,
  input  logic [INPUT_WIDTH-1:0]     y_in,
  input  logic [FLIP_FLAG_WIDTH-1:0] flip_in,
  input  logic                       arctan_en_in,
  input  logic                       valid_in,
  output logic [OUTPUT_WIDTH-1:0]    x_out,
  output logic [OUTPUT_WIDTH-1:0]    y_out,
  output logic [OUTPUT_WIDTH-1:0]    z_out,
  output logic [FLIP_FLAG_WIDTH-1:0] flip_out,
  output logic                       arctan_en_out,
  output logic                       valid_out
);

  localparam int c_W        = ITERATION_WORD_WIDTH;
  localparam int c_N        = ITERATION_NUMBER;
  // Q7.8 sample -> Q12.20 word
  localparam int c_IN_SHIFT = ITERATION_WORD_FRAC_WIDTH - INPUT_FRAC_WIDTH;
  // integer degrees -> Q12.20 degrees
  localparam int c_Z_SHIFT  = ITERATION_WORD_FRAC_WIDTH;
  // LSBs dropped when reducing a word to the output format
  localparam int c_DROP     = ITERATION_WORD_FRAC_WIDTH - OUTPUT_FRAC_WIDTH;
  localparam int c_KEEP     = c_W - c_DROP;

  // atan(2^-idx) in degrees, tabulated with 20 fractional bits and rescaled
  // to the internal fractional width. Deep iterations fall back to the
  // small-angle approximation (180/pi) * 2^-idx.
  function automatic logic [c_W-1:0] atan_deg(input int idx);
    logic [63:0] v;
    case (idx)
      0:       v = 64'd47185920;
      1:       v = 64'd27855475;
      2:       v = 64'd14718068;
      3:       v = 64'd7471121;
      4:       v = 64'd3750058;
      5:       v = 64'd1876857;
      6:       v = 64'd938658;
      7:       v = 64'd469357;
      8:       v = 64'd234682;
      9:       v = 64'd117342;
      10:      v = 64'd58671;
      11:      v = 64'd29335;
      12:      v = 64'd14668;
      13:      v = 64'd7334;
      14:      v = 64'd3667;
      15:      v = 64'd1833;
      default: v = 64'd60078979 >> idx;
    endcase
    return c_W'((v << ITERATION_WORD_FRAC_WIDTH) >> 20);
  endfunction

  // Floor-reduce a Q12.20 word to the output width; clamp when the bits above
  // the output window are not a pure sign extension.
  function automatic logic [OUTPUT_WIDTH-1:0] reduce_sat(input logic [c_W-1:0] v);
    logic [c_KEEP-1:0]              t;
    logic [c_KEEP-OUTPUT_WIDTH:0]   top;
    logic [OUTPUT_WIDTH-1:0]        r;
    t   = v[c_W-1:c_DROP];
    top = t[c_KEEP-1:OUTPUT_WIDTH-1];
    if ((&top) || !(|top)) begin
      r = t[OUTPUT_WIDTH-1:0];
    end else begin
      r = {t[c_KEEP-1], {(OUTPUT_WIDTH-1){~t[c_KEEP-1]}}};
    end
    return r;
  endfunction

  // Stage s holds the state after s iterations; stage 0 is the input register.
  logic signed [c_W-1:0]      x_d     [0:c_N];
  logic signed [c_W-1:0]      y_d     [0:c_N];
  logic signed [c_W-1:0]      z_d     [0:c_N];
  logic [FLIP_FLAG_WIDTH-1:0] flip_d  [0:c_N];
  logic                       mode_d  [0:c_N];
  logic                       valid_d [0:c_N];

  logic signed [c_W-1:0]      x_q     [0:c_N];
  logic signed [c_W-1:0]      y_q     [0:c_N];
  logic signed [c_W-1:0]      z_q     [0:c_N];
  logic [FLIP_FLAG_WIDTH-1:0] flip_q  [0:c_N];
  logic                       mode_q  [0:c_N];
  logic                       valid_q [0:c_N];

  logic [OUTPUT_WIDTH-1:0]    x_out_d, y_out_d, z_out_d;
  logic [OUTPUT_WIDTH-1:0]    x_out_q, y_out_q, z_out_q;
  logic [FLIP_FLAG_WIDTH-1:0] flip_out_q;
  logic                       mode_out_q;
  logic                       valid_out_q;

  // Input stage: rotation starts from (x,0) with z = angle; vectoring starts
  // from (x,y) with z = 0.
  assign x_d[0]     = c_W'($signed(x_in)) << c_IN_SHIFT;
  assign y_d[0]     = arctan_en_in ? (c_W'($signed(y_in)) << c_IN_SHIFT) : '0;
  assign z_d[0]     = arctan_en_in ? '0 : (c_W'($signed(degree_in)) << c_Z_SHIFT);
  assign flip_d[0]  = flip_in;
  assign mode_d[0]  = arctan_en_in;
  assign valid_d[0] = valid_in;

  for (genvar i = 0; i < c_N; i++) begin : g_stage
    localparam logic signed [c_W-1:0] c_ATAN = atan_deg(i);

    logic signed [c_W-1:0] w_x_sh;
    logic signed [c_W-1:0] w_y_sh;
    logic                  w_ccw;

    assign w_x_sh = x_q[i] >>> i;
    assign w_y_sh = y_q[i] >>> i;
    // Counter-clockwise micro-rotation drives a positive residual angle down
    // (rotation) or a negative y up toward zero (vectoring).
    assign w_ccw  = mode_q[i] ? y_q[i][c_W-1] : ~z_q[i][c_W-1];

    assign x_d[i+1]     = w_ccw ? (x_q[i] - w_y_sh) : (x_q[i] + w_y_sh);
    assign y_d[i+1]     = w_ccw ? (y_q[i] + w_x_sh) : (y_q[i] - w_x_sh);
    assign z_d[i+1]     = w_ccw ? (z_q[i] - c_ATAN) : (z_q[i] + c_ATAN);
    assign flip_d[i+1]  = flip_q[i];
    assign mode_d[i+1]  = mode_q[i];
    assign valid_d[i+1] = valid_q[i];
  end

  assign x_out_d = reduce_sat(x_q[c_N]);
  assign y_out_d = reduce_sat(y_q[c_N]);
  assign z_out_d = reduce_sat(z_q[c_N]);

  // Advance the input register and every iteration stage on enabled edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s <= c_N; s++) begin
        x_q[s]     <= '0;
        y_q[s]     <= '0;
        z_q[s]     <= '0;
        flip_q[s]  <= '0;
        mode_q[s]  <= 1'b0;
        valid_q[s] <= 1'b0;
      end
    end else if (enable) begin
      for (int s = 0; s <= c_N; s++) begin
        x_q[s]     <= x_d[s];
        y_q[s]     <= y_d[s];
        z_q[s]     <= z_d[s];
        flip_q[s]  <= flip_d[s];
        mode_q[s]  <= mode_d[s];
        valid_q[s] <= valid_d[s];
      end
    end
  end

  // Output register: capture the saturated Q7.8 results and their flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_out_q     <= '0;
      y_out_q     <= '0;
      z_out_q     <= '0;
      flip_out_q  <= '0;
      mode_out_q  <= 1'b0;
      valid_out_q <= 1'b0;
    end else if (enable) begin
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
      z_out_q     <= z_out_d;
      flip_out_q  <= flip_q[c_N];
      mode_out_q  <= mode_q[c_N];
      valid_out_q <= valid_q[c_N];
    end
  end

  assign x_out         = x_out_q;
  assign y_out         = y_out_q;
  assign z_out         = z_out_q;
  assign flip_out      = flip_out_q;
  assign arctan_en_out = mode_out_q;
  assign valid_out     = valid_out_q;

endmodule
`default_nettype wire

// File: tb/tb_cordic_pipeline.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cordic_pipeline
//  Description : Self-checking bench for cordic_pipeline. A real-arithmetic
//                angle table and an integer CORDIC model predict every result;
//                a monitor records each valid output with its enabled-edge
//                index so latency and ordering are compared too.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_pipeline;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] degree_in, x_in, y_in;
  logic [0:0]  flip_in;
  logic        arctan_en_in, valid_in;
  logic [15:0] x_out, y_out, z_out;
  logic [0:0]  flip_out;
  logic        arctan_en_out, valid_out;

  cordic_pipeline dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .degree_in    (degree_in),
    .x_in         (x_in),
    .y_in         (y_in),
    .flip_in      (flip_in),
    .arctan_en_in (arctan_en_in),
    .valid_in     (valid_in),
    .x_out        (x_out),
    .y_out        (y_out),
    .z_out        (z_out),
    .flip_out     (flip_out),
    .arctan_en_out(arctan_en_out),
    .valid_out    (valid_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic        flip;
    logic        mode;
    int          e;
  } res_t;

  res_t exp_q[$];
  res_t obs_q[$];
  int   errors = 0;
  int   checks = 0;
  int   edge_n = 0;
  bit   en_at_edge;
  int   atan_tab[6];

  function automatic logic [15:0] to_q78(int v);
    int q;
    q = v >>> 12;
    if (q > 32767)  return 16'h7FFF;
    if (q < -32768) return 16'h8000;
    return 16'(q);
  endfunction

  function automatic res_t model(logic mode, logic [15:0] deg, logic [15:0] x,
                                 logic [15:0] y, logic flip);
    int   xv, yv, zv, xt;
    bit   ccw;
    res_t r;
    xv = int'($signed(x)) * 4096;
    if (mode) begin
      yv = int'($signed(y)) * 4096;
      zv = 0;
    end else begin
      yv = 0;
      zv = int'($signed(deg)) * 1048576;
    end
    for (int i = 0; i < 6; i++) begin
      ccw = mode ? (yv < 0) : (zv >= 0);
      xt  = xv;
      if (ccw) begin
        xv = xv - (yv >>> i);
        yv = yv + (xt >>> i);
        zv = zv - atan_tab[i];
      end else begin
        xv = xv + (yv >>> i);
        yv = yv - (xt >>> i);
        zv = zv + atan_tab[i];
      end
    end
    r.x    = to_q78(xv);
    r.y    = to_q78(yv);
    r.z    = to_q78(zv);
    r.flip = flip;
    r.mode = mode;
    r.e    = 0;
    return r;
  endfunction

  // One clock; record valid outputs seen on enabled edges.
  task automatic tick();
    res_t o;
    @(posedge clk);
    en_at_edge = enable;
    #1;
    if (rst_n && en_at_edge) begin
      edge_n++;
      if (valid_out) begin
        o.x = x_out; o.y = y_out; o.z = z_out;
        o.flip = flip_out[0]; o.mode = arctan_en_out; o.e = edge_n;
        obs_q.push_back(o);
      end
    end
  endtask

  task automatic send(logic v, logic mode, logic [15:0] deg, logic [15:0] x,
                      logic [15:0] y, logic flip);
    res_t r;
    valid_in = v; arctan_en_in = mode; degree_in = deg;
    x_in = x; y_in = y; flip_in = flip;
    tick();
    if (en_at_edge && v && rst_n) begin
      r   = model(mode, deg, x, y, flip);
      r.e = edge_n + 7;
      exp_q.push_back(r);
    end
  endtask

  task automatic idle(int n);
    repeat (n) send(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1;
    valid_in = 0; arctan_en_in = 0; degree_in = 0; x_in = 0; y_in = 0; flip_in = 0;
    repeat (2) tick();
    checks++;
    if ({x_out, y_out, z_out, flip_out, arctan_en_out, valid_out} !== 51'h0) begin
      errors++;
      $display("FAIL reset_state: got x=%h y=%h z=%h f=%b m=%b v=%b, want all zero",
               x_out, y_out, z_out, flip_out, arctan_en_out, valid_out);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++)
      send(1'b1, 1'(i % 2), 16'(i * 5), 16'h0100, 16'h0080, 1'(i % 2));
    checks++;
    if (valid_out !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_valid: got valid_out=%b, want 1", valid_out);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({x_out, y_out, z_out, flip_out, arctan_en_out, valid_out} !== 51'h0) begin
      errors++;
      $display("FAIL async_reset: got x=%h y=%h z=%h f=%b m=%b v=%b, want all zero",
               x_out, y_out, z_out, flip_out, arctan_en_out, valid_out);
    end
    tick();
    rst_n = 1'b1;
    exp_q.delete(); obs_q.delete();
    idle(10);
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL no_valid_after_reset: got %0d valid outputs, want 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_rotation_zero();
    res_t r, o;
    send(1'b1, 1'b0, 16'd0, 16'h0100, 16'h0, 1'b0);
    idle(8);
    r = exp_q.pop_front();
    checks++;
    if (obs_q.size() != 1) begin
      errors++;
      $display("FAIL rot0_count: got %0d outputs, want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      checks++;
      if (o !== r) begin
        errors++;
        $display("FAIL rot0_exact: got x=%h y=%h z=%h e=%0d, want x=%h y=%h z=%h e=%0d",
                 o.x, o.y, o.z, o.e, r.x, r.y, r.z, r.e);
      end
      checks++;
      if (int'($signed(o.x)) < 16'h01A3 || int'($signed(o.x)) > 16'h01A7) begin
        errors++;
        $display("FAIL rot0_gain: got x=%h, want 01a5+-2", o.x);
      end
      checks++;
      if (int'($signed(o.y)) < -8 || int'($signed(o.y)) > 8) begin
        errors++;
        $display("FAIL rot0_y: got y=%h, want within +-0008", o.y);
      end
      checks++;
      if (int'($signed(o.z)) < -459 || int'($signed(o.z)) > 459) begin
        errors++;
        $display("FAIL rot0_z: got z=%h, want |z|<=01cb", o.z);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_vectoring_45();
    res_t r, o;
    send(1'b1, 1'b1, 16'd0, 16'h0100, 16'h0100, 1'b1);
    idle(8);
    r = exp_q.pop_front();
    checks++;
    if (obs_q.size() != 1) begin
      errors++;
      $display("FAIL vec45_count: got %0d outputs, want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      checks++;
      if (o !== r) begin
        errors++;
        $display("FAIL vec45_exact: got x=%h y=%h z=%h m=%b e=%0d, want x=%h y=%h z=%h m=%b e=%0d",
                 o.x, o.y, o.z, o.mode, o.e, r.x, r.y, r.z, r.mode, r.e);
      end
      checks++;
      if (int'($signed(o.z)) < 16'h2D00 - 459 || int'($signed(o.z)) > 16'h2D00 + 459) begin
        errors++;
        $display("FAIL vec45_angle: got z=%h, want 2d00+-01cb", o.z);
      end
      checks++;
      if (o.mode !== 1'b1) begin
        errors++;
        $display("FAIL vec45_mode: got arctan_en_out=%b, want 1", o.mode);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    res_t r, o;
    int   d;
    for (int i = 0; i < 20; i++) begin
      d = int'($urandom_range(180)) - 90;
      send(1'b1, 1'(i % 2), 16'(d), 16'($urandom), 16'($urandom), 1'((i + 1) % 2));
    end
    idle(8);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count: got %0d outputs, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL b2b_missing: got no output, want x=%h y=%h z=%h e=%0d", r.x, r.y, r.z, r.e);
      end else begin
        o = obs_q.pop_front();
        if (o !== r) begin
          errors++;
          $display("FAIL b2b_sample: got x=%h y=%h z=%h f=%b m=%b e=%0d, want x=%h y=%h z=%h f=%b m=%b e=%0d",
                   o.x, o.y, o.z, o.flip, o.mode, o.e, r.x, r.y, r.z, r.flip, r.mode, r.e);
        end
      end
    end
    obs_q.delete();
  endtask

  task automatic test_stall();
    res_t        r, o;
    logic [50:0] snap;
    send(1'b1, 1'b0, 16'd30,  16'h0200, 16'h0, 1'b1);
    send(1'b1, 1'b1, 16'd0,   16'h0180, 16'hFF00, 1'b0);
    for (int pass = 0; pass < 2; pass++) begin
      snap   = {x_out, y_out, z_out, flip_out, arctan_en_out, valid_out};
      enable = 1'b0;
      for (int k = 0; k < 3; k++) begin
        send(1'b1, 1'b1, 16'd45, 16'h1234, 16'h4321, 1'b1);
        checks++;
        if ({x_out, y_out, z_out, flip_out, arctan_en_out, valid_out} !== snap) begin
          errors++;
          $display("FAIL stall_frozen: got %h, want %h",
                   {x_out, y_out, z_out, flip_out, arctan_en_out, valid_out}, snap);
        end
      end
      enable = 1'b1;
      if (pass == 0) begin
        send(1'b1, 1'b0, 16'hFFC4, 16'h0100, 16'h0, 1'b0);
        send(1'b1, 1'b1, 16'd0,    16'hFF00, 16'h0080, 1'b1);
        idle(4);
      end
    end
    idle(8);
    checks++;
    if (obs_q.size() != 4) begin
      errors++;
      $display("FAIL stall_count: got %0d outputs, want 4", obs_q.size());
    end
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL stall_missing: got no output, want x=%h y=%h z=%h e=%0d", r.x, r.y, r.z, r.e);
      end else begin
        o = obs_q.pop_front();
        if (o !== r) begin
          errors++;
          $display("FAIL stall_sample: got x=%h y=%h z=%h f=%b m=%b e=%0d, want x=%h y=%h z=%h f=%b m=%b e=%0d",
                   o.x, o.y, o.z, o.flip, o.mode, o.e, r.x, r.y, r.z, r.flip, r.mode, r.e);
        end
      end
    end
    obs_q.delete();
  endtask

  task automatic test_saturation();
    res_t r, o;
    send(1'b1, 1'b0, 16'd90,   16'h7FFF, 16'h0, 1'b0);
    send(1'b1, 1'b0, 16'hFFA6, 16'h7FFF, 16'h0, 1'b1);
    idle(8);
    checks++;
    if (obs_q.size() != 2) begin
      errors++;
      $display("FAIL sat_count: got %0d outputs, want 2", obs_q.size());
    end
    for (int k = 0; k < 2; k++) begin
      r = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL sat_missing: got no output, want y=%h", r.y);
      end else begin
        o = obs_q.pop_front();
        if (o !== r) begin
          errors++;
          $display("FAIL sat_exact: got x=%h y=%h z=%h e=%0d, want x=%h y=%h z=%h e=%0d",
                   o.x, o.y, o.z, o.e, r.x, r.y, r.z, r.e);
        end
        checks++;
        if (o.y !== ((k == 0) ? 16'h7FFF : 16'h8000)) begin
          errors++;
          $display("FAIL sat_clamp: got y=%h, want %h", o.y, (k == 0) ? 16'h7FFF : 16'h8000);
        end
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 6; i++)
      atan_tab[i] = int'($atan(2.0 ** (-i)) * 180.0 / (4.0 * $atan(1.0)) * 1048576.0);
    test_reset();
    test_rotation_zero();
    test_vectoring_45();
    test_back_to_back();
    test_stall();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, want finish before time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
